// File: rtl/fir_pkg.sv
// Shared definitions for the FIR datapath blocks: default widths, clog2 and the
// common shift/round/saturate helper.
package fir_pkg;

   localparam int unsigned DEF_DATA_W = 16;
   localparam int unsigned DEF_COEF_W = 16;
   localparam int unsigned DEF_TAPS   = 64;

   // Working width of the round/saturate helper; callers sign-extend into it.
   localparam int unsigned RS_W = 128;

   typedef struct packed {
      logic signed [RS_W-1:0] val;
      logic                   sat;
   } rs_t;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < n) r++;
      return r;
   endfunction

   // Round half up by 'shift' bits, then optionally clamp to a signed out_w range.
   function automatic rs_t round_sat(input logic signed [RS_W-1:0] sum,
                                     input int unsigned shift,
                                     input int unsigned out_w,
                                     input logic sat_en);
      rs_t                    res;
      logic signed [RS_W-1:0] r;
      logic signed [RS_W-1:0] hi;
      logic signed [RS_W-1:0] lo;
      r = sum;
      if (shift > 0) r = r + (RS_W'(1) << (shift - 1));
      r = r >>> shift;
      hi = (RS_W'(1) << (out_w - 1)) - 1;
      lo = ~hi;
      res.val = r;
      res.sat = 1'b0;
      if (sat_en) begin
         if (r > hi) begin
            res.val = hi;
            res.sat = 1'b1;
         end else if (r < lo) begin
            res.val = lo;
            res.sat = 1'b1;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/fir_mac_acc_if.sv
// Stream bus of the FIR MAC engine: sample/coeff input handshake, result output
// handshake, frame flush and tap position.
interface fir_mac_acc_if import fir_pkg::*; #(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned COEF_W = DEF_COEF_W,
   parameter int unsigned OUT_W  = 32,
   parameter int unsigned TAPS   = DEF_TAPS
) ();

   localparam int unsigned IDX_W = clog2(TAPS);

   logic                     clear;
   logic                     in_valid;
   logic                     in_ready;
   logic signed [DATA_W-1:0] x;
   logic signed [COEF_W-1:0] coeff;
   logic                     out_valid;
   logic                     out_ready;
   logic        [OUT_W-1:0]  y;
   logic                     y_sat;
   logic        [IDX_W-1:0]  tap_idx;

   modport master (
      output clear, in_valid, x, coeff, out_ready,
      input  in_ready, out_valid, y, y_sat, tap_idx
   );

   modport slave (
      input  clear, in_valid, x, coeff, out_ready,
      output in_ready, out_valid, y, y_sat, tap_idx
   );

endinterface

// File: rtl/fir_round_sat.sv
// Combinational output stage: arithmetic shift with round-half-up, then optional
// saturation to OUT_W with a clip flag.
module fir_round_sat import fir_pkg::*; #(
   parameter int unsigned IN_W   = 34,
   parameter int unsigned OUT_W  = 32,
   parameter int unsigned SHIFT  = 0,
   parameter bit          SAT_EN = 1'b1
) (
   input  logic signed [IN_W-1:0]  i_sum,
   output logic        [OUT_W-1:0] o_y,
   output logic                    o_sat
);

   logic signed [RS_W-1:0] w_sum_ext;
   rs_t                    w_res;
   logic                   w_unused;

   assign w_sum_ext = RS_W'(i_sum);
   assign w_res     = round_sat(w_sum_ext, SHIFT, OUT_W, SAT_EN);
   assign o_y       = w_res.val[OUT_W-1:0];
   assign o_sat     = w_res.sat;
   // Bits above OUT_W are only meaningful in wrap mode, where they are dropped.
   assign w_unused  = ^w_res.val[RS_W-1:OUT_W];

endmodule

// File: rtl/fir_mac_acc.sv
// Pipelined multiply-accumulate: product stage, accumulate stage and a registered
// rounded/saturated output, all frozen together while the output is backpressured.
module fir_mac_acc import fir_pkg::*; #(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned COEF_W = DEF_COEF_W,
   parameter int unsigned TAPS   = DEF_TAPS,
   parameter int unsigned OUT_W  = 32,
   parameter int unsigned SHIFT  = 0,
   parameter bit          SAT_EN = 1'b1
) (
   input logic           clk,
   input logic           rst,
   fir_mac_acc_if.slave  io_bus
);

   localparam int unsigned PROD_W = DATA_W + COEF_W;
   localparam int unsigned IDX_W  = clog2(TAPS);
   localparam int unsigned ACC_W  = PROD_W + IDX_W;

   logic        [IDX_W-1:0]  r_tap_idx;
   logic signed [PROD_W-1:0] r_p;
   logic                     r_p_vld;
   logic                     r_p_last;
   logic                     r_p_first;
   logic signed [ACC_W-1:0]  r_acc;
   logic                     r_acc_last;
   logic                     r_out_valid;
   logic        [OUT_W-1:0]  r_y;
   logic                     r_y_sat;

   logic                     w_adv;
   logic                     w_in_ready;
   logic                     w_accept;
   logic                     w_last_tap;
   logic signed [PROD_W-1:0] w_prod;
   logic signed [ACC_W-1:0]  w_acc_base;
   logic        [OUT_W-1:0]  w_y;
   logic                     w_y_sat;

   assign w_adv      = !(r_out_valid && !io_bus.out_ready);
   assign w_in_ready = w_adv && !rst && !io_bus.clear;
   assign w_accept   = io_bus.in_valid && w_in_ready;
   assign w_last_tap = (r_tap_idx == IDX_W'(TAPS - 1));
   assign w_prod     = PROD_W'(io_bus.x) * PROD_W'(io_bus.coeff);
   // The first product of a frame overwrites, so frames can run back to back.
   assign w_acc_base = r_p_first ? '0 : r_acc;

   fir_round_sat #(
      .IN_W   (ACC_W),
      .OUT_W  (OUT_W),
      .SHIFT  (SHIFT),
      .SAT_EN (SAT_EN)
   ) u_round_sat (
      .i_sum (r_acc),
      .o_y   (w_y),
      .o_sat (w_y_sat)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tap_idx   <= '0;
         r_p         <= '0;
         r_p_vld     <= 1'b0;
         r_p_last    <= 1'b0;
         r_p_first   <= 1'b0;
         r_acc       <= '0;
         r_acc_last  <= 1'b0;
         r_out_valid <= 1'b0;
         r_y         <= '0;
         r_y_sat     <= 1'b0;
      end else begin
         if (io_bus.clear) begin
            r_tap_idx  <= '0;
            r_p_vld    <= 1'b0;
            r_acc      <= '0;
            r_acc_last <= 1'b0;
         end else if (w_adv) begin
            r_p_vld <= w_accept;
            if (w_accept) begin
               r_p       <= w_prod;
               r_p_last  <= w_last_tap;
               r_p_first <= (r_tap_idx == '0);
               r_tap_idx <= w_last_tap ? '0 : r_tap_idx + IDX_W'(1);
            end
            if (r_p_vld) r_acc <= w_acc_base + ACC_W'(r_p);
            r_acc_last <= r_p_vld && r_p_last;
         end
         // A pending result is never flushed by clear, only replaced or consumed.
         if (w_adv) begin
            r_out_valid <= r_acc_last;
            if (r_acc_last) begin
               r_y     <= w_y;
               r_y_sat <= w_y_sat;
            end
         end
      end
   end

   assign io_bus.in_ready  = w_in_ready;
   assign io_bus.out_valid = r_out_valid;
   assign io_bus.y         = r_y;
   assign io_bus.y_sat     = r_y_sat;
   assign io_bus.tap_idx   = r_tap_idx;

endmodule

// File: tb/tb_fir_mac_acc.sv
// Bench for fir_mac_acc: three instances (saturating, wrapping, shifted) share one
// stimulus stream; a reference model fills the expected queue on each accepted pair.
module tb_fir_mac_acc;

   localparam int unsigned TAPS = 4;
   localparam int unsigned DW   = 16;
   localparam int unsigned CW   = 16;
   localparam int unsigned OW   = 32;
   localparam longint      MAX32 = (longint'(1) <<< 31) - 1;
   localparam longint      MIN32 = -(longint'(1) <<< 31);

   typedef struct packed {
      logic [31:0] y;
      logic        sat;
   } res_t;

   typedef struct packed {
      res_t d0;
      res_t d1;
      res_t d2;
   } trio_t;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 clear;
   logic                 in_valid;
   logic                 out_ready;
   logic signed [15:0]   x;
   logic signed [15:0]   coeff;

   trio_t  exp_q[$];
   trio_t  got_q[$];
   trio_t  mon_t;
   int     errors = 0;
   int     checks = 0;
   longint m_sum  = 0;
   int     m_cnt  = 0;

   always #5 clk = ~clk;

   fir_mac_acc_if #(.DATA_W(DW), .COEF_W(CW), .OUT_W(OW), .TAPS(TAPS)) if0 ();
   fir_mac_acc_if #(.DATA_W(DW), .COEF_W(CW), .OUT_W(OW), .TAPS(TAPS)) if1 ();
   fir_mac_acc_if #(.DATA_W(DW), .COEF_W(CW), .OUT_W(OW), .TAPS(TAPS)) if2 ();

   assign if0.clear = clear;     assign if1.clear = clear;     assign if2.clear = clear;
   assign if0.in_valid = in_valid; assign if1.in_valid = in_valid; assign if2.in_valid = in_valid;
   assign if0.x = x;             assign if1.x = x;             assign if2.x = x;
   assign if0.coeff = coeff;     assign if1.coeff = coeff;     assign if2.coeff = coeff;
   assign if0.out_ready = out_ready; assign if1.out_ready = out_ready;
   assign if2.out_ready = out_ready;

   fir_mac_acc #(.DATA_W(DW), .COEF_W(CW), .TAPS(TAPS), .OUT_W(OW), .SHIFT(0), .SAT_EN(1'b1))
      dut0 (.clk(clk), .rst(rst), .io_bus(if0.slave));
   fir_mac_acc #(.DATA_W(DW), .COEF_W(CW), .TAPS(TAPS), .OUT_W(OW), .SHIFT(0), .SAT_EN(1'b0))
      dut1 (.clk(clk), .rst(rst), .io_bus(if1.slave));
   fir_mac_acc #(.DATA_W(DW), .COEF_W(CW), .TAPS(TAPS), .OUT_W(OW), .SHIFT(2), .SAT_EN(1'b1))
      dut2 (.clk(clk), .rst(rst), .io_bus(if2.slave));

   function automatic res_t ref_out(input longint sum, input int shift, input bit sat_en);
      res_t   o;
      longint r;
      r = sum;
      if (shift > 0) r = r + (longint'(1) <<< (shift - 1));
      r = r >>> shift;
      o.y   = r[31:0];
      o.sat = 1'b0;
      if (sat_en && r > MAX32) begin
         o.y   = 32'h7fff_ffff;
         o.sat = 1'b1;
      end else if (sat_en && r < MIN32) begin
         o.y   = 32'h8000_0000;
         o.sat = 1'b1;
      end
      return o;
   endfunction

   // Model and output capture, sampled mid-cycle.
   always @(negedge clk) begin
      if (rst) begin
         m_sum = 0;
         m_cnt = 0;
      end else begin
         if (clear) begin
            m_sum = 0;
            m_cnt = 0;
         end else if (in_valid && if0.in_ready) begin
            m_sum = m_sum + longint'(x) * longint'(coeff);
            m_cnt++;
            if (m_cnt == TAPS) begin
               mon_t.d0 = ref_out(m_sum, 0, 1'b1);
               mon_t.d1 = ref_out(m_sum, 0, 1'b0);
               mon_t.d2 = ref_out(m_sum, 2, 1'b1);
               exp_q.push_back(mon_t);
               m_sum = 0;
               m_cnt = 0;
            end
         end
         if (if0.out_valid && out_ready) begin
            mon_t.d0.y = if0.y; mon_t.d0.sat = if0.y_sat;
            mon_t.d1.y = if1.y; mon_t.d1.sat = if1.y_sat;
            mon_t.d2.y = if2.y; mon_t.d2.sat = if2.y_sat;
            got_q.push_back(mon_t);
         end
      end
   end

   // Call at posedge+1; returns at posedge+1 right after the handshake edge.
   task automatic drive_pair(input shortint xv, input shortint cv);
      int n;
      n = 0;
      in_valid = 1'b1;
      x        = xv;
      coeff    = cv;
      @(negedge clk);
      while (!if0.in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         checks++;
         errors++;
         $display("FAIL drive_timeout: in_ready=%0b after %0d cycles, required 1", if0.in_ready, n);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_outputs(input int n, input int max_cycles);
      for (int i = 0; i < max_cycles && got_q.size() < n; i++) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (if0.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_in_ready: got %b, required 0", if0.in_ready);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checks += 5;
      if (if0.out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_out_valid: got %b, required 0", if0.out_valid);
      end
      if (if0.y !== 32'd0) begin
         errors++; $display("FAIL reset_y: got %h, required 0", if0.y);
      end
      if (if0.y_sat !== 1'b0) begin
         errors++; $display("FAIL reset_y_sat: got %b, required 0", if0.y_sat);
      end
      if (if0.tap_idx !== 2'd0) begin
         errors++; $display("FAIL reset_tap_idx: got %0d, required 0", if0.tap_idx);
      end
      if (if0.in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_release_in_ready: got %b, required 1", if0.in_ready);
      end
   endtask

   task automatic test_basic();
      trio_t   g;
      trio_t   e;
      shortint xs[4];
      shortint cs[4];
      bit      exp_v[4];
      xs    = '{1, 2, 3, 4};
      cs    = '{5, 6, 7, 8};
      exp_v = '{0, 0, 1, 0};
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) drive_pair(xs[i], cs[i]);
      checks++;
      if (if0.tap_idx !== 2'd0) begin
         errors++; $display("FAIL basic_tap_wrap: got %0d, required 0", if0.tap_idx);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (if0.out_valid !== exp_v[i]) begin
            errors++;
            $display("FAIL basic_latency[%0d]: out_valid=%b, required %b", i, if0.out_valid, exp_v[i]);
         end
         if (exp_v[i]) begin
            checks++;
            if (if0.y !== 32'd70 || if0.y_sat !== 1'b0) begin
               errors++;
               $display("FAIL basic_y: got y=%0d sat=%b, required 70 sat=0", $signed(if0.y), if0.y_sat);
            end
         end
      end
      wait_outputs(1, 20);
      checks++;
      if (got_q.size() !== exp_q.size()) begin
         errors++;
         $display("FAIL basic_count: got %0d results, required %0d", got_q.size(), exp_q.size());
      end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
         if (g !== e) begin
            errors++; $display("FAIL basic_result: got %h, required %h", g, e);
         end
      end
   endtask

   task automatic test_saturation();
      trio_t g;
      trio_t e;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) drive_pair(-16'sd32768, -16'sd32768);
      wait_outputs(1, 20);
      checks++;
      if (got_q.size() !== 1 || exp_q.size() !== 1) begin
         errors++;
         $display("FAIL sat_count: got %0d results, required 1 (model %0d)", got_q.size(), exp_q.size());
      end
      if (got_q.size() > 0) begin
         g = got_q[0];
         checks += 2;
         if (g.d0.y !== 32'h7fff_ffff || g.d0.sat !== 1'b1) begin
            errors++; $display("FAIL sat_clip: got y=%h sat=%b, required 7fffffff sat=1", g.d0.y, g.d0.sat);
         end
         if (g.d1.y !== 32'd0 || g.d1.sat !== 1'b0) begin
            errors++; $display("FAIL sat_wrap: got y=%h sat=%b, required 0 sat=0", g.d1.y, g.d1.sat);
         end
      end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
         if (g !== e) begin
            errors++; $display("FAIL sat_result: got %h, required %h", g, e);
         end
      end
   endtask

   task automatic test_round();
      trio_t   g;
      trio_t   e;
      shortint xs[4];
      xs = '{1, 2, 1, 2};
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) drive_pair(xs[i], xs[i]);
      for (int i = 0; i < 4; i++) drive_pair(-xs[i], xs[i]);
      wait_outputs(2, 30);
      checks++;
      if (got_q.size() !== 2 || exp_q.size() !== 2) begin
         errors++;
         $display("FAIL round_count: got %0d results, required 2 (model %0d)", got_q.size(), exp_q.size());
      end
      if (got_q.size() == 2) begin
         checks += 2;
         if (got_q[0].d2.y !== 32'd3) begin
            errors++; $display("FAIL round_pos: got %0d, required 3", $signed(got_q[0].d2.y));
         end
         if (got_q[1].d2.y !== 32'hffff_fffe) begin
            errors++; $display("FAIL round_neg: got %0d, required -2", $signed(got_q[1].d2.y));
         end
      end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
         if (g !== e) begin
            errors++; $display("FAIL round_result: got %h, required %h", g, e);
         end
      end
   endtask

   task automatic test_backpressure();
      trio_t g;
      trio_t e;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      fork
         begin
            for (int i = 0; i < 4; i++) drive_pair(shortint'(i + 1), shortint'(i + 5));
            for (int i = 0; i < 4; i++) drive_pair(shortint'(i + 2), 16'sd1);
         end
         begin
            int          n;
            logic [31:0] y_hold;
            n = 0;
            @(negedge clk);
            while (!if0.out_valid && n < 50) begin
               @(negedge clk);
               n++;
            end
            checks++;
            if (n >= 50) begin
               errors++; $display("FAIL bp_timeout: out_valid=%b, required 1", if0.out_valid);
            end
            y_hold = if0.y;
            checks++;
            if (y_hold !== 32'd70) begin
               errors++; $display("FAIL bp_first: got %0d, required 70", $signed(y_hold));
            end
            for (int i = 0; i < 5; i++) begin
               checks += 2;
               if (if0.in_ready !== 1'b0) begin
                  errors++; $display("FAIL bp_in_ready[%0d]: got %b, required 0", i, if0.in_ready);
               end
               if (if0.out_valid !== 1'b1 || if0.y !== y_hold) begin
                  errors++;
                  $display("FAIL bp_hold[%0d]: got valid=%b y=%0d, required 1 %0d", i, if0.out_valid,
                           $signed(if0.y), $signed(y_hold));
               end
               if (i < 4) @(negedge clk);
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      wait_outputs(2, 40);
      checks++;
      if (got_q.size() !== 2 || exp_q.size() !== 2) begin
         errors++;
         $display("FAIL bp_count: got %0d results, required 2 (model %0d)", got_q.size(), exp_q.size());
      end
      if (got_q.size() == 2) begin
         checks++;
         if (got_q[0].d0.y !== 32'd70 || got_q[1].d0.y !== 32'd14) begin
            errors++;
            $display("FAIL bp_order: got %0d,%0d, required 70,14", $signed(got_q[0].d0.y),
                     $signed(got_q[1].d0.y));
         end
      end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
         if (g !== e) begin
            errors++; $display("FAIL bp_result: got %h, required %h", g, e);
         end
      end
   endtask

   task automatic test_clear();
      trio_t g;
      trio_t e;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      drive_pair(16'sd9, 16'sd9);
      drive_pair(16'sd9, 16'sd9);
      clear    = 1'b1;
      in_valid = 1'b1;
      x        = 16'sd100;
      coeff    = 16'sd100;
      @(negedge clk);
      checks++;
      if (if0.in_ready !== 1'b0) begin
         errors++; $display("FAIL clear_in_ready: got %b, required 0", if0.in_ready);
      end
      @(posedge clk);
      #1;
      clear    = 1'b0;
      in_valid = 1'b0;
      checks++;
      if (if0.tap_idx !== 2'd0) begin
         errors++; $display("FAIL clear_tap_idx: got %0d, required 0", if0.tap_idx);
      end
      for (int i = 0; i < 4; i++) drive_pair(16'sd1, 16'sd1);
      wait_outputs(1, 20);
      checks++;
      if (got_q.size() !== 1 || exp_q.size() !== 1) begin
         errors++;
         $display("FAIL clear_count: got %0d results, required 1 (model %0d)", got_q.size(), exp_q.size());
      end
      if (got_q.size() > 0) begin
         checks++;
         if (got_q[0].d0.y !== 32'd4) begin
            errors++; $display("FAIL clear_y: got %0d, required 4", $signed(got_q[0].d0.y));
         end
      end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
         if (g !== e) begin
            errors++; $display("FAIL clear_result: got %h, required %h", g, e);
         end
      end
   endtask

   task automatic test_reset_midframe();
      trio_t g;
      trio_t e;
      int    n;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) drive_pair(shortint'(i + 1), shortint'(i + 5));
      drive_pair(16'sd3, 16'sd3);
      n = 0;
      @(negedge clk);
      while (!if0.out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks += 2;
      if (if0.out_valid !== 1'b1) begin
         errors++; $display("FAIL rstmid_pending: out_valid=%b, required 1", if0.out_valid);
      end
      if (if0.tap_idx !== 2'd1) begin
         errors++; $display("FAIL rstmid_tap_before: got %0d, required 1", if0.tap_idx);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (if0.in_ready !== 1'b0) begin
         errors++; $display("FAIL rstmid_in_ready: got %b, required 0", if0.in_ready);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checks += 3;
      if (if0.out_valid !== 1'b0) begin
         errors++; $display("FAIL rstmid_out_valid: got %b, required 0", if0.out_valid);
      end
      if (if0.tap_idx !== 2'd0) begin
         errors++; $display("FAIL rstmid_tap_idx: got %0d, required 0", if0.tap_idx);
      end
      if (if0.y !== 32'd0) begin
         errors++; $display("FAIL rstmid_y: got %h, required 0", if0.y);
      end
      exp_q.delete();
      got_q.delete();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) drive_pair(shortint'(i + 1), shortint'(i + 5));
      wait_outputs(1, 20);
      checks++;
      if (got_q.size() !== 1 || exp_q.size() !== 1) begin
         errors++;
         $display("FAIL rstmid_count: got %0d results, required 1 (model %0d)", got_q.size(), exp_q.size());
      end
      if (got_q.size() > 0) begin
         checks++;
         if (got_q[0].d0.y !== 32'd70) begin
            errors++; $display("FAIL rstmid_y_after: got %0d, required 70", $signed(got_q[0].d0.y));
         end
      end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
         if (g !== e) begin
            errors++; $display("FAIL rstmid_result: got %h, required %h", g, e);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst       = 1'b1;
      clear     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      x         = '0;
      coeff     = '0;
      test_reset();
      test_basic();
      test_saturation();
      test_round();
      test_backpressure();
      test_clear();
      test_reset_midframe();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fir_mac_acc.md
Name: fir_mac_acc

Overview:
- Parametrised, pipelined multiply-accumulate engine for the FIR datapath. Next generation of the fixed 64-tap MAC.
- Accepts one signed sample/coefficient pair per cycle over a valid/ready handshake and sums TAPS products.
- Emits one rounded, optionally saturated result per TAPS accepted pairs on a valid/ready output.
- Backpressure stalls the pipeline; no result is ever dropped.

Parameters:
- DATA_W, 16: sample width, signed two's complement.
- COEF_W, 16: coefficient width, signed.
- TAPS, 64: products summed per output. Must be at least 2.
- OUT_W, 32: result width.
- SHIFT, 0: arithmetic right shift applied to the sum before output. Range 0..(ACC_W-1).
- SAT_EN, 1: 1 saturates the output to OUT_W; 0 keeps the low OUT_W bits (wrap).

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous reset, active-high.
- clear, in, 1: synchronous flush of the accumulation in progress.
- in_valid, in, 1: x/coeff pair valid.
- in_ready, out, 1: pair accepted when in_valid && in_ready.
- x, in, DATA_W: sample.
- coeff, in, COEF_W: coefficient.
- out_valid, out, 1: result valid.
- out_ready, in, 1: result consumed when out_valid && out_ready.
- y, out, OUT_W: result.
- y_sat, out, 1: result was clipped. Qualified by out_valid.
- tap_idx, out, clog2(TAPS): index of the next pair to be accepted.

Behaviour:
- Reset: out_valid=0, y=0, y_sat=0, tap_idx=0, accumulator=0, pipeline valids=0.
- Reset mid-frame discards all partial state. in_ready=0 during the reset cycle.
- Widths:
  - PROD_W = DATA_W+COEF_W.
  - ACC_W = PROD_W+clog2(TAPS).
  - The accumulator cannot overflow for any inputs.
- Global advance: adv = !(out_valid && !out_ready). in_ready = adv && !rst.
- When adv=0, every pipeline register holds its value.
- S1 (product stage), on acceptance:
  - p <= signed(x)*signed(coeff); p_vld <= 1; p_last <= (tap_idx==TAPS-1).
  - tap_idx wraps to 0 after TAPS-1.
  - On an advance cycle with no acceptance, p_vld <= 0.
- S2 (accumulate stage), when adv && p_vld:
  - acc <= (p_first ? 0 : acc) + sext(p). The first product of a frame overwrites the accumulator, so no dead cycle is needed between frames.
  - If p_last, the final sum goes to the output stage.
- Output stage, on final sum:
  - r = sum + (SHIFT>0 ? 1<<(SHIFT-1) : 0), then r >>>= SHIFT (round half up).
  - SAT_EN=1 clamps r to [-2^(OUT_W-1), 2^(OUT_W-1)-1] and sets y_sat if clipped.
  - SAT_EN=0 gives y = r[OUT_W-1:0] and y_sat=0.
  - out_valid <= 1.
- Latency: out_valid rises 2 cycles after the handshake of the last tap, with no stalls.
- Throughput: 1 pair/cycle sustained when out_ready=1.
- out_valid clears on the consume cycle unless a new result loads in the same cycle. Back-to-back results with no gap are legal.
- y/y_sat hold stable while out_valid && !out_ready.
- clear:
  - Zeroes tap_idx, p_vld and the accumulator.
  - Does not touch a pending output (out_valid/y kept).
  - The pair presented in the clear cycle is not accepted: in_ready=0 while clear=1.
- clear and rst in the same cycle: rst wins (identical effect on shared state).
- in_valid=0 mid-frame is a bubble and changes no result.

Decomposition:
- Shared package fir_pkg:
  - clog2 function.
  - Constants DEF_DATA_W, DEF_COEF_W, DEF_TAPS.
  - Rounding/saturation helper function, shared with later filter blocks.
- One sub-module: fir_round_sat (combinational shift, round, clamp, sat flag). Reused by the decimator output stage.

Test Plan (bench parameters: TAPS=4, DATA_W=COEF_W=16, OUT_W=32, SHIFT=0, SAT_EN=1):
1. Pairs x={1,2,3,4}, coeff={5,6,7,8} back-to-back, out_ready=1 -> y=70, y_sat=0, out_valid for 1 cycle, 2 cycles after the 4th handshake. tap_idx returns to 0.
2. x=-32768, coeff=-32768 for 4 taps, OUT_W=32 -> sum=2^32 exceeds range -> y=2147483647, y_sat=1. Rerun with SAT_EN=0 -> y=0, y_sat=0.
3. SHIFT=2, products summing to 10 -> y=3 (10+2>>2). Sum -10 -> y=-2.
4. Two frames streamed continuously while out_ready is held low for 5 cycles after the first result -> in_ready=0 during the hold, first y held stable. Both results delivered in order (70, then the second sum), none lost.
5. clear pulsed after tap 2 of a frame, then a full frame {1,1,1,1}x{1,1,1,1} -> y=4. No partial sum leaks in.
6. rst asserted for 1 cycle mid-frame while an output is pending -> out_valid=0, tap_idx=0. A following frame yields the correct y with no residue.
